hazard_ctrl: RTL and testbench

- Consumer-side controller for the ID/EX pipeline register.
- Compares ID-stage operand/stack requirements against the instruction held in ID/EX and against EX-stage redirects.
- Drives PC/IF-ID write enables and IF-ID/ID-EX flushes.
- Inserts multi-cycle bubbles for load-use, stack, and control-flow hazards; sits beside the decode stage and is clocked with the pipeline registers.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_down_counter.sv | 38 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
package hazard_pkg;

    localparam int HZ_CNT_W      = 3;
    localparam int HZ_REG_ADDR_W = 3;

    // Single-cycle stack stalls never leave RUN, so they need no state of their own.
    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        FLUSH
    } hz_state_t;

    typedef struct packed {
        logic pc_write_en;
        logic ifid_write_en;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = '{pc_write_en: 1'b1, ifid_write_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{pc_write_en: 1'b0, ifid_write_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write_en: 1'b1, ifid_write_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable saturating down-counter with zero flag; async active-high reset.
module hazard_down_counter
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [HZ_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic [HZ_CNT_W-1:0] cnt,
    output logic                zero
);

    logic [HZ_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - HZ_CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use / stack stalls and EX-redirect flushes.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_cycles counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W            = HZ_REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES     = 1,
    parameter int REDIRECT_FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_stack_op,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_RF_write_en,
    input  logic                  ex_MEM_read,
    input  logic                  ex_stack_op,
    input  logic                  ex_redirect,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_cycles,
`endif
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  busy
);

    // Reload values count the cycles remaining after the one that triggers the hazard.
    localparam logic [HZ_CNT_W-1:0] LOAD_RELOAD  = HZ_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [HZ_CNT_W-1:0] FLUSH_RELOAD = HZ_CNT_W'(REDIRECT_FLUSH_CYCLES - 1);

    hz_state_t           state_q, state_d;
    hz_ctrl_t            ctrl, ctrl_out;
    logic                cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [HZ_CNT_W-1:0] cnt_val, cnt;
    logic                load_hz, stack_hz;

    assign load_hz  = ex_MEM_read & ex_RF_write_en &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign stack_hz = id_stack_op & ex_stack_op;
    assign cnt_last = cnt_zero | (cnt == HZ_CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        ctrl     = CTRL_RUN;
        cnt_load = 1'b0;
        cnt_val  = LOAD_RELOAD;
        cnt_dec  = 1'b0;
        if (ex_redirect) begin
            ctrl     = CTRL_FLUSH;
            cnt_load = 1'b1;
            cnt_val  = FLUSH_RELOAD;
            state_d  = (FLUSH_RELOAD == '0) ? RUN : FLUSH;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    ctrl    = CTRL_FLUSH;
                    cnt_dec = 1'b1;
                    if (cnt_last) state_d = RUN;
                end
                LOAD_STALL: begin
                    ctrl    = CTRL_FREEZE;
                    cnt_dec = 1'b1;
                    if (cnt_last) state_d = RUN;
                end
                default: begin
                    if (load_hz) begin
                        ctrl     = CTRL_FREEZE;
                        cnt_load = 1'b1;
                        state_d  = (LOAD_RELOAD == '0) ? RUN : LOAD_STALL;
                    end else if (stack_hz) begin
                        ctrl = CTRL_FREEZE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    hazard_down_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Outputs are forced to the free-running values while reset is held.
    assign ctrl_out      = rst ? CTRL_RUN : ctrl;
    assign pc_write_en   = ctrl_out.pc_write_en;
    assign ifid_write_en = ctrl_out.ifid_write_en;
    assign ifid_flush    = ctrl_out.ifid_flush;
    assign idex_flush    = ctrl_out.idex_flush;
    assign busy          = !rst && (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!ctrl_out.pc_write_en && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
        if (ctrl_out.ifid_flush && (flush_q != 16'hFFFF))   flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two instances (load stall 1 and 3 cycles) against a remaining-cycles model.
module tb_hazard_ctrl;

    localparam int AW    = 3;
    localparam int FLUSH_N = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 0, id_use_rs2 = 0, id_stack_op = 0;
    logic          ex_RF_write_en = 0, ex_MEM_read = 0, ex_stack_op = 0, ex_redirect = 0;

    logic pc_a, ifwe_a, iffl_a, idfl_a, busy_a;
    logic pc_b, ifwe_b, iffl_b, idfl_b, busy_b;

    int total  = 0;
    int passed = 0;
    int frz_left[2];
    int fl_left[2];

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_a, flush_a, stall_b, flush_b;
    int stall_m[2];
    int flush_m[2];
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_stack_op(id_stack_op),
        .ex_rd(ex_rd), .ex_RF_write_en(ex_RF_write_en), .ex_MEM_read(ex_MEM_read),
        .ex_stack_op(ex_stack_op), .ex_redirect(ex_redirect),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_a), .flush_cycles(flush_a),
`endif
        .pc_write_en(pc_a), .ifid_write_en(ifwe_a), .ifid_flush(iffl_a),
        .idex_flush(idfl_a), .busy(busy_a)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_FLUSH_CYCLES(FLUSH_N)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_stack_op(id_stack_op),
        .ex_rd(ex_rd), .ex_RF_write_en(ex_RF_write_en), .ex_MEM_read(ex_MEM_read),
        .ex_stack_op(ex_stack_op), .ex_redirect(ex_redirect),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_b), .flush_cycles(flush_b),
`endif
        .pc_write_en(pc_b), .ifid_write_en(ifwe_b), .ifid_flush(iffl_b),
        .idex_flush(idfl_b), .busy(busy_b)
    );

    function automatic int load_n(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // {pc_write_en, ifid_write_en, ifid_flush, idex_flush, busy}
    function automatic logic [4:0] dut_out(int k);
        return (k == 0) ? {pc_a, ifwe_a, iffl_a, idfl_a, busy_a}
                        : {pc_b, ifwe_b, iffl_b, idfl_b, busy_b};
    endfunction

    function automatic bit model_load_hz();
        return ex_MEM_read && ex_RF_write_en &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [4:0] model_out(int k);
        logic bz;
        if (rst) return 5'b11000;
        bz = (frz_left[k] > 0) || (fl_left[k] > 0);
        if (ex_redirect)                               return {4'b1111, bz};
        if (fl_left[k] > 0)                            return 5'b11111;
        if (frz_left[k] > 0)                           return 5'b00011;
        if (model_load_hz() || (id_stack_op && ex_stack_op)) return 5'b00010;
        return 5'b11000;
    endfunction

    // Wait for the active edge and advance the remaining-cycle model with the inputs of that cycle.
    task automatic model_tick();
        logic [4:0] o [2];
        @(posedge clk);
        for (int k = 0; k < 2; k++) o[k] = model_out(k);
        for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_PERF_CNT_EN
            if (rst) begin
                stall_m[k] = 0;
                flush_m[k] = 0;
            end else begin
                if (!o[k][4] && stall_m[k] < 65535) stall_m[k]++;
                if (o[k][2] && flush_m[k] < 65535)  flush_m[k]++;
            end
`endif
            if (rst) begin
                frz_left[k] = 0;
                fl_left[k]  = 0;
            end else if (ex_redirect) begin
                fl_left[k]  = FLUSH_N - 1;
                frz_left[k] = 0;
            end else if (fl_left[k] > 0) begin
                fl_left[k]--;
            end else if (frz_left[k] > 0) begin
                frz_left[k]--;
            end else if (model_load_hz()) begin
                frz_left[k] = load_n(k) - 1;
            end
        end
    endtask

    task automatic drive_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_stack_op = 0;
        ex_RF_write_en = 0; ex_MEM_read = 0; ex_stack_op = 0; ex_redirect = 0;
    endtask

    task automatic drive_load_hz();
        ex_MEM_read = 1; ex_RF_write_en = 1; ex_rd = 3'd3;
        id_rs1 = 3'd3; id_use_rs1 = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        ex_redirect = 1;
        drive_load_hz();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 5'b11000) $display("FAIL reset inst%0d got=%b exp=11000", k, dut_out(k));
            else passed++;
        end
        model_tick();
        @(negedge clk);
        drive_idle();
        rst = 0;
        model_tick();
    endtask

    task automatic test_load_stall();
        int frz[2] = '{0, 0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) drive_load_hz();
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== model_out(k))
                    $display("FAIL load_stall c%0d inst%0d got=%b exp=%b", c, k, dut_out(k), model_out(k));
                else passed++;
                if (!dut_out(k)[4]) frz[k]++;
            end
            model_tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (frz[k] != load_n(k)) $display("FAIL load_stall_len inst%0d got=%0d exp=%0d", k, frz[k], load_n(k));
            else passed++;
        end
    endtask

    task automatic test_redirect();
        int fl[2] = '{0, 0};
        int pcz[2] = '{0, 0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) ex_redirect = 1;
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== model_out(k))
                    $display("FAIL redirect c%0d inst%0d got=%b exp=%b", c, k, dut_out(k), model_out(k));
                else passed++;
                if (dut_out(k)[2]) fl[k]++;
                if (!dut_out(k)[4]) pcz[k]++;
            end
            model_tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (fl[k] != FLUSH_N || pcz[k] != 0)
                $display("FAIL redirect_len inst%0d flush=%0d freeze=%0d exp=%0d/0", k, fl[k], pcz[k], FLUSH_N);
            else passed++;
        end
    endtask

    task automatic test_abort();
        int frz[2] = '{0, 0};
        int fl[2]  = '{0, 0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) drive_load_hz();
            if (c == 1) ex_redirect = 1;
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== model_out(k))
                    $display("FAIL abort c%0d inst%0d got=%b exp=%b", c, k, dut_out(k), model_out(k));
                else passed++;
                if (!dut_out(k)[4]) frz[k]++;
                if (dut_out(k)[2])  fl[k]++;
            end
            model_tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (frz[k] != 1 || fl[k] != FLUSH_N)
                $display("FAIL abort_len inst%0d freeze=%0d flush=%0d exp=1/%0d", k, frz[k], fl[k], FLUSH_N);
            else passed++;
        end
    endtask

    task automatic test_stack();
        int frz[2] = '{0, 0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0 || c == 2) begin
                id_stack_op = 1;
                ex_stack_op = 1;
            end
            if (c == 2) drive_load_hz();
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== model_out(k))
                    $display("FAIL stack c%0d inst%0d got=%b exp=%b", c, k, dut_out(k), model_out(k));
                else passed++;
                if (!dut_out(k)[4]) frz[k]++;
            end
            model_tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (frz[k] != 1 + load_n(k)) $display("FAIL stack_len inst%0d got=%0d exp=%0d", k, frz[k], 1 + load_n(k));
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_idle();
        ex_redirect = 1;
        model_tick();
        @(negedge clk);
        drive_idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 5'b11111) $display("FAIL mid_flush inst%0d got=%b exp=11111", k, dut_out(k));
            else passed++;
        end
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 5'b11000) $display("FAIL async_reset inst%0d got=%b exp=11000", k, dut_out(k));
            else passed++;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if ({stall_a, flush_a, stall_b, flush_b} !== 64'd0)
            $display("FAIL perf_reset got=%h %h %h %h exp=0", stall_a, flush_a, stall_b, flush_b);
        else passed++;
`endif
        model_tick();
        @(negedge clk);
        rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dut_out(k) !== 5'b11000) $display("FAIL post_reset inst%0d got=%b exp=11000", k, dut_out(k));
            else passed++;
        end
        model_tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            id_rs1         = AW'($urandom_range(0, 3));
            id_rs2         = AW'($urandom_range(0, 3));
            ex_rd          = AW'($urandom_range(0, 3));
            id_use_rs1     = 1'($urandom);
            id_use_rs2     = 1'($urandom);
            ex_RF_write_en = 1'($urandom);
            ex_MEM_read    = ($urandom_range(0, 2) == 0);
            id_stack_op    = ($urandom_range(0, 3) == 0);
            ex_stack_op    = ($urandom_range(0, 3) == 0);
            ex_redirect    = ($urandom_range(0, 9) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dut_out(k) !== model_out(k))
                    $display("FAIL random c%0d inst%0d got=%b exp=%b", c, k, dut_out(k), model_out(k));
                else passed++;
            end
            model_tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        total++;
        if (stall_a !== 16'(stall_m[0]) || flush_a !== 16'(flush_m[0]) ||
            stall_b !== 16'(stall_m[1]) || flush_b !== 16'(flush_m[1]))
            $display("FAIL perf_counts got=%0d %0d %0d %0d exp=%0d %0d %0d %0d",
                     stall_a, flush_a, stall_b, flush_b, stall_m[0], flush_m[0], stall_m[1], flush_m[1]);
        else passed++;
`endif
        drive_idle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            frz_left[k] = 0;
            fl_left[k]  = 0;
`ifdef HAZARD_PERF_CNT_EN
            stall_m[k] = 0;
            flush_m[k] = 0;
`endif
        end
        test_reset();
        test_load_stall();
        test_redirect();
        test_abort();
        test_stack();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
